cheat_engine_multi: RTL

//  Next-generation ROM patch and hook detector with SLOTS programmable patch slots (the current block has 6 fixed slots).

---
 rtl/cheat_pkg.sv | 18 +
 rtl/cheat_vector_fsm.sv | 78 +++++++
 rtl/cheat_engine_multi.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cheat_pkg.sv
// Shared types and constants for the ROM patch / vector-hook engine.
package cheat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    ARMED
  } vec_state_e;

  localparam logic [23:0] NMI_VEC = 24'h00FFEA;
  localparam logic [23:0] IRQ_VEC = 24'h00FFEE;

  localparam int unsigned CTRL_CHEAT_EN   = 0;
  localparam int unsigned CTRL_NMI_EN     = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_HOLDOFF_EN = 3;

endpackage

// File: rtl/cheat_vector_fsm.sv
// Detects interrupt entry (descending B-bus push writes) followed by a
// vector low-byte fetch; emits a registered 1-clk {irq,nmi} pulse.
module cheat_vector_fsm
  import cheat_pkg::*;
#(
  parameter int PUSH_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic        i_reset,
  input  logic [7:0]  i_pa,
  input  logic [23:0] i_addr,
  input  logic        i_nmi_en,
  input  logic        i_irq_en,
  input  logic        i_hooks_active,
  output logic [1:0]  o_vector_fetch
);

  localparam int CW = $clog2(PUSH_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(PUSH_BYTES);

  vec_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_exp;
  logic [1:0]    r_vec;
  logic [1:0]    w_vec;

  always_comb begin
    w_vec    = '0;
    w_vec[0] = (i_addr == NMI_VEC) & i_nmi_en & i_hooks_active;
    w_vec[1] = (i_addr == IRQ_VEC) & i_irq_en & i_hooks_active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_vec   <= '0;
    end else begin
      r_vec <= '0;
      if (i_reset) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (i_wr) begin
            r_state <= PUSH;
            r_cnt   <= CW'(1);
            r_exp   <= i_pa - 8'd1;
          end
          PUSH: if (i_wr) begin
            if (i_pa == r_exp) begin
              if (r_cnt != FULL) r_cnt <= r_cnt + CW'(1);
              r_exp <= r_exp - 8'd1;
            end else begin
              r_cnt <= CW'(1);
              r_exp <= i_pa - 8'd1;
            end
          end else if (i_rd) begin
            // A full push arms on this very read, so the ARMED decode is folded in here.
            if (r_cnt == FULL) r_vec <= w_vec;
            r_state <= IDLE;
          end
          ARMED: if (i_rd) begin
            r_vec   <= w_vec;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_vector_fetch = r_vec;

endmodule

// File: rtl/cheat_engine_multi.sv
// Programmable ROM patch slots with masks, reset holdoff and vector hooks.
// Optional per-slot hit counters when CHEAT_HITCNT_EN is defined.
module cheat_engine_multi
  import cheat_pkg::*;
#(
  parameter int SLOTS          = 16,
  parameter int HOLDOFF_CYCLES = 960000000,
  parameter int PUSH_BYTES     = 4,
  localparam int IW            = $clog2(SLOTS + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [23:0]   SNES_ADDR,
  input  logic [7:0]    SNES_PA,
  input  logic          SNES_wr_strobe,
  input  logic          SNES_rd_strobe,
  input  logic          SNES_reset_strobe,
  input  logic          SNES_cycle_start,
  input  logic          pgm_we,
  input  logic [IW-1:0] pgm_idx,
  input  logic [31:0]   pgm_in,
  input  logic [4:0]    cnt_idx,
  output logic [7:0]    data_out,
  output logic          cheat_hit,
  output logic [1:0]    vector_fetch,
  output logic          hooks_active,
  output logic [7:0]    cnt_out
);

  localparam int unsigned NS = SLOTS;

  logic [23:0]   r_addr [NS];
  logic [7:0]    r_data [NS];
  logic [23:0]   r_mask [NS];
  logic [NS-1:0] r_en;
  logic [3:0]    r_ctrl;
  logic [29:0]   r_holdoff;
  logic [NS-1:0] r_match;
  logic [NS-1:0] w_match;
  logic [31:0]   w_pidx;
  logic [31:0]   w_cidx;
  logic [7:0]    w_data;
  logic          w_found;

  assign w_pidx = 32'(pgm_idx);
  assign w_cidx = 32'(cnt_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NS; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
      r_en   <= '0;
      r_ctrl <= '0;
    end else if (pgm_we) begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (w_pidx == i) begin
          r_addr[i] <= pgm_in[31:8];
          r_data[i] <= pgm_in[7:0];
        end
      end
      if (w_pidx == NS) r_en <= pgm_in[NS-1:0];
      if (w_pidx == NS + 1) r_ctrl <= (r_ctrl & ~pgm_in[11:8]) | pgm_in[3:0];
      if (w_pidx == NS + 2) begin
        for (int unsigned i = 0; i < NS; i++) begin
          if (w_cidx == i) r_mask[i] <= pgm_in[23:0];
        end
      end
    end
  end

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      w_match[i] = r_en[i] & r_ctrl[CTRL_CHEAT_EN] &
                   (((SNES_ADDR ^ r_addr[i]) & ~r_mask[i]) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_match <= '0;
    else        r_match <= w_match;
  end

  // Lowest-index matching slot wins.
  always_comb begin
    w_data  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (r_match[i] && !w_found) begin
        w_data  = r_data[i];
        w_found = 1'b1;
      end
    end
  end

  assign data_out  = w_data;
  assign cheat_hit = |r_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdoff <= '0;
    end else if (SNES_reset_strobe && r_ctrl[CTRL_HOLDOFF_EN]) begin
      r_holdoff <= 30'(HOLDOFF_CYCLES);
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - 30'd1;
    end
  end

  assign hooks_active = (r_holdoff == '0) & (r_ctrl[CTRL_NMI_EN] | r_ctrl[CTRL_IRQ_EN]);

  cheat_vector_fsm #(
    .PUSH_BYTES(PUSH_BYTES)
  ) u_vector_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_wr           (SNES_wr_strobe),
    .i_rd           (SNES_rd_strobe),
    .i_reset        (SNES_reset_strobe),
    .i_pa           (SNES_PA),
    .i_addr         (SNES_ADDR),
    .i_nmi_en       (r_ctrl[CTRL_NMI_EN]),
    .i_irq_en       (r_ctrl[CTRL_IRQ_EN]),
    .i_hooks_active (hooks_active),
    .o_vector_fetch (vector_fetch)
  );

`ifdef CHEAT_HITCNT_EN
  logic [7:0] r_hitcnt [NS];
  logic [7:0] r_cnt_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NS; i++) r_hitcnt[i] <= '0;
      r_cnt_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (SNES_reset_strobe || (pgm_we && w_pidx == i)) begin
          r_hitcnt[i] <= '0;
        end else if (SNES_cycle_start && r_match[i] && r_hitcnt[i] != 8'hFF) begin
          r_hitcnt[i] <= r_hitcnt[i] + 8'd1;
        end
      end
      r_cnt_out <= '0;
      for (int unsigned i = 0; i < NS; i++) begin
        if (w_cidx == i) r_cnt_out <= r_hitcnt[i];
      end
    end
  end

  assign cnt_out = r_cnt_out;
`else
  logic w_unused_cycle_start;
  assign w_unused_cycle_start = SNES_cycle_start;
  assign cnt_out = '0;
`endif

endmodule
